data_modulate_5x5_datapath: RTL and testbench
=============================================

Name: data_modulate_5x5_datapath

Overview:
- Streaming 5x5 window generator feeding the 5x5 data-modulate controller.
- Accepts raster-order pixels, buffers four image rows, and emits one zero-padded 5x5 neighbourhood per image pixel.
- Inserts its own padding columns and rows.
- Reports end-of-frame flush progress to the controller on i_counter and done_reg.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 640, pixels per row W (>= 5)
IMG_HEIGHT, 480, rows per frame H (>= 5)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  frame start pulse from controller; clears counters and buffers
i_data  input  DATA_WIDTH  input pixel
i_valid  input  1  i_data valid
ready_o  output  1  block accepts i_data this cycle
o_window  output  25*DATA_WIDTH  window; tap (i,j) at bits [(5*i+j)*DATA_WIDTH +: DATA_WIDTH], pixel (r-2+i, c-2+j)
o_valid  output  1  o_window valid, one cycle per window
i_counter  output  3  flush progress 0..3
done_reg  output  1  registered "done already reported" flag

Behaviour:
- One clock (clk). Synchronous active-high reset (rst). Reset priority is above start.
- Reset values:
  - State IDLE.
  - ready_o=0, o_valid=0, o_window=0, i_counter=0, done_reg=0.
  - Column counter=0, row counter=0.
  - Line buffers need not be cleared; they are masked by padding logic.
- States: IDLE, STREAM, PAD_COL, FLUSH, DONE.
- IDLE: ready_o=0. start moves the block to STREAM and clears row/col counters, i_counter and done_reg.
- STREAM:
  - ready_o=1. A pixel is accepted when i_valid && ready_o. No state change without acceptance.
  - Each accepted pixel shifts into the 5x5 window register and into the line-buffer chain (4 buffers, depth W).
  - col increments on each accepted pixel.
  - At col==W-1, go to PAD_COL.
- PAD_COL:
  - Exactly 2 cycles, ready_o=0. A zero is shifted in per cycle.
  - Line buffers are not written.
  - Afterwards: col=0 and row++. Go to STREAM if row < H-1, else go to FLUSH with i_counter=1.
- FLUSH:
  - ready_o=0.
  - Internally generates 2 zero rows of W+2 cycles each (W pixel slots plus 2 pad slots). Line buffers advance as in STREAM.
  - i_counter=1 during flush row 1 and 2 during flush row 2.
  - When the last cycle of flush row 2 completes, i_counter becomes 3 and the state becomes DONE.
- DONE:
  - i_counter holds 3. done_reg is set to 1 on the cycle after i_counter first equals 3.
  - The controller's done_o is therefore a single-cycle pulse.
  - start returns the block to STREAM and clears i_counter and done_reg.
- Window emission:
  - Let (R,C) be the logical input position, counting pad columns and flush rows.
  - When R>=2 and C>=2, the window centred at (R-2,C-2) is registered onto o_window with o_valid=1 in the following cycle (latency 1).
  - Rows R<2 and columns C<2 emit nothing.
  - Total H*W windows per frame, in raster order of centre.
- Padding: any tap whose source row <0, row >=H, col <0 or col >=W reads 0 regardless of buffer contents.
- No backpressure on output. o_valid pulses are never stalled.
- i_valid=0 in STREAM: no shift, no emission. Bubbles are allowed anywhere in a row.
- start while not IDLE/DONE: aborts the frame and restarts in STREAM with counters cleared. Stale buffer data is masked by padding.
- rst mid-frame: immediate return to reset values on the next edge.

Test Plan:
- W=8,H=6, start, then 48 pixels with value = 8*row+col+1 and i_valid always high:
  - exactly 48 o_valid pulses;
  - first window centre (0,0) has tap(2,2)=1, tap(2,3)=2, tap(3,2)=9, and 0 in rows 0-1 and cols 0-1;
  - last window centre (5,7) has tap(2,2)=48, tap(1,1)=39, and 0 in rows 3-4 and cols 3-4.
- Same frame: ready_o is low for exactly 2 cycles after each 8th accepted pixel; no pixel is accepted while ready_o=0 even with i_valid=1.
- Same frame, end:
  - i_counter goes 1 for 10 cycles, then 2 for 10 cycles, then 3;
  - done_reg rises exactly one cycle after i_counter==3 and holds;
  - controller done_o pulses 1 cycle.
- Random i_valid (~50% duty) on a W=8,H=6 frame: window sequence and values identical to the first scenario; o_valid count is 48.
- rst asserted at pixel 20: next cycle all outputs are 0 and state is IDLE. A new start plus a full frame produces correct windows with no leakage of pre-reset pixels.
- start in DONE: i_counter and done_reg clear on the next cycle, ready_o=1; a second frame with all pixels 0xFF produces 0xFF at in-image taps and 0 at padded taps.

Source files
------------

// File: rtl/data_modulate_5x5_datapath_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : data_modulate_5x5_datapath_if
// Description : Pixel-in / window-out stream bundle for the 5x5 datapath.
//               The master drives pixels and observes ready and windows; the
//               slave (datapath) accepts pixels and produces windows.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface data_modulate_5x5_datapath_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]    i_data;
   logic                     i_valid;
   logic                     ready_o;
   logic [25*DATA_WIDTH-1:0] o_window;
   logic                     o_valid;

   modport master (
      output i_data,
      output i_valid,
      input  ready_o,
      input  o_window,
      input  o_valid
   );

   modport slave (
      input  i_data,
      input  i_valid,
      output ready_o,
      output o_window,
      output o_valid
   );
endinterface
`default_nettype wire

// File: rtl/data_modulate_5x5_datapath.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : data_modulate_5x5_datapath
// Description : Streaming 5x5 window generator. Buffers four image rows,
//               inserts two zero pad columns per row and two zero flush rows
//               per frame, and emits one zero-padded 5x5 neighbourhood per
//               image pixel in raster order of the window centre.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module data_modulate_5x5_datapath #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   input  wire logic                   start,
   data_modulate_5x5_datapath_if.slave bus,
   output logic [2:0]                  i_counter,
   output logic                        done_reg
);

   // Column counter spans W pixel slots plus 2 pad slots; row counter spans
   // H image rows plus 2 flush rows plus the final terminal increment.
   localparam int CW = $clog2(IMG_WIDTH + 2);
   localparam int RW = $clog2(IMG_HEIGHT + 3);
   localparam int AW = $clog2(IMG_WIDTH);

   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] PAD_COL0 = CW'(IMG_WIDTH);
   localparam logic [CW-1:0] ROW_END  = CW'(IMG_WIDTH + 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_STREAM  = 3'd1,
      S_PAD_COL = 3'd2,
      S_FLUSH   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            col_q, col_d;
   logic [RW-1:0]            row_q, row_d;
   logic [2:0]               i_counter_q, i_counter_d;
   logic                     done_reg_q, done_reg_d;
   logic                     ready_o_q, ready_o_d;
   logic                     o_valid_q, o_valid_d;
   logic [25*DATA_WIDTH-1:0] o_window_q, o_window_d;

   logic                     shift;     // one logical position consumed
   logic [DATA_WIDTH-1:0]    pix;       // value entering at that position
   logic                     pad_slot;  // current column is a pad column
   logic [AW-1:0]            lb_addr;

   logic [DATA_WIDTH-1:0]    lb_mem [4][IMG_WIDTH];
   logic [DATA_WIDTH-1:0]    lb_rd  [4];
   logic [DATA_WIDTH-1:0]    col_in [5];
   logic [DATA_WIDTH-1:0]    win_q  [5][5];
   logic [DATA_WIDTH-1:0]    win_d  [5][5];

   assign pad_slot = (col_q >= PAD_COL0);
   assign lb_addr  = col_q[AW-1:0];

   // Frame sequencing: pixel acceptance, pad columns, flush rows, done flag.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      i_counter_d = i_counter_q;
      done_reg_d  = done_reg_q;
      shift       = 1'b0;
      pix         = '0;
      case (state_q)
         S_IDLE: begin
         end
         S_STREAM: begin
            if (bus.i_valid) begin
               shift = 1'b1;
               pix   = bus.i_data;
               col_d = col_q + CW'(1);
               if (col_q == LAST_COL) begin
                  state_d = S_PAD_COL;
               end
            end
         end
         S_PAD_COL: begin
            shift = 1'b1;
            if (col_q == ROW_END) begin
               col_d = '0;
               row_d = row_q + RW'(1);
               if (row_q < LAST_ROW) begin
                  state_d = S_STREAM;
               end else begin
                  state_d     = S_FLUSH;
                  i_counter_d = 3'd1;
               end
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         S_FLUSH: begin
            shift = 1'b1;
            if (col_q == ROW_END) begin
               col_d = '0;
               row_d = row_q + RW'(1);
               if (i_counter_q == 3'd1) begin
                  i_counter_d = 3'd2;
               end else begin
                  i_counter_d = 3'd3;
                  state_d     = S_DONE;
               end
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         S_DONE: begin
            // First DONE cycle has i_counter==3; the flag follows one cycle later.
            done_reg_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // start restarts a frame from any state; stale buffers are masked later.
      if (start) begin
         state_d     = S_STREAM;
         col_d       = '0;
         row_d       = '0;
         i_counter_d = 3'd0;
         done_reg_d  = 1'b0;
         shift       = 1'b0;
      end
      ready_o_d = (state_d == S_STREAM);
   end

   // Line-buffer taps and the next window: shift left, new column on the right.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lb_rd[k] = lb_mem[k][lb_addr];
      end
      col_in[4] = pix;
      for (int k = 0; k < 4; k++) begin
         col_in[3-k] = pad_slot ? '0 : lb_rd[k];
      end
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 4; j++) begin
            win_d[i][j] = win_q[i][j+1];
         end
         win_d[i][4] = col_in[i];
      end
   end

   // Emit the window centred two rows/cols behind the input, zeroing taps
   // whose source pixel lies outside the image.
   always_comb begin
      o_valid_d  = 1'b0;
      o_window_d = o_window_q;
      if (shift && (row_q >= RW'(2)) && (col_q >= CW'(2))) begin
         o_valid_d  = 1'b1;
         o_window_d = '0;
         for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
               if ((int'(row_q) + i >= 4) && (int'(row_q) + i < IMG_HEIGHT + 4) &&
                   (int'(col_q) + j >= 4) && (int'(col_q) + j < IMG_WIDTH + 4)) begin
                  o_window_d[(5*i+j)*DATA_WIDTH +: DATA_WIDTH] = win_d[i][j];
               end
            end
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         i_counter_q <= 3'd0;
         done_reg_q  <= 1'b0;
         ready_o_q   <= 1'b0;
         o_valid_q   <= 1'b0;
         o_window_q  <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         i_counter_q <= i_counter_d;
         done_reg_q  <= done_reg_d;
         ready_o_q   <= ready_o_d;
         o_valid_q   <= o_valid_d;
         o_window_q  <= o_window_d;
      end
   end

   // Window and line-buffer storage; contents are masked, so no reset needed.
   always_ff @(posedge clk) begin
      if (shift) begin
         win_q <= win_d;
         if (!pad_slot) begin
            lb_mem[0][lb_addr] <= pix;
            for (int k = 1; k < 4; k++) begin
               lb_mem[k][lb_addr] <= lb_rd[k-1];
            end
         end
      end
   end

   assign bus.ready_o  = ready_o_q;
   assign bus.o_valid  = o_valid_q;
   assign bus.o_window = o_window_q;
   assign i_counter    = i_counter_q;
   assign done_reg     = done_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_data_modulate_5x5_datapath.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_data_modulate_5x5_datapath
// Description : Self-checking bench for the 5x5 window datapath on an 8x6
//               image. Expected windows come from a direct neighbourhood
//               model of the input image.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_data_modulate_5x5_datapath;

   localparam int DW    = 8;
   localparam int W     = 8;
   localparam int H     = 6;
   localparam int WIN_W = 25 * DW;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] i_counter;
   logic       done_reg;

   int checks   = 0;
   int failures = 0;
   int kind     = 0;   // 0: pixel = index+1, 1: all 0xFF
   int win_idx  = 0;
   logic [WIN_W-1:0] cap [W*H];

   data_modulate_5x5_datapath_if #(.DATA_WIDTH(DW)) bus ();

   data_modulate_5x5_datapath #(
      .DATA_WIDTH(DW),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus.slave),
      .i_counter(i_counter),
      .done_reg (done_reg)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pix_val(input int k, input int idx);
      if (k == 0) return DW'(idx + 1);
      return 8'hFF;
   endfunction

   // Neighbourhood of centre (r,c) straight from the image, zero outside it.
   function automatic logic [WIN_W-1:0] model_window(input int k, input int r, input int c);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            int rr, cc;
            rr = r - 2 + i;
            cc = c - 2 + j;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
               w[(5*i+j)*DW +: DW] = pix_val(k, rr*W + cc);
         end
      end
      return w;
   endfunction

   function automatic logic [DW-1:0] tap(input logic [WIN_W-1:0] w, input int i, input int j);
      return w[(5*i+j)*DW +: DW];
   endfunction

   // OR of every tap in rows lo..hi or cols lo..hi.
   function automatic logic [DW-1:0] band_or(input logic [WIN_W-1:0] w, input int lo, input int hi);
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            if ((i >= lo && i <= hi) || (j >= lo && j <= hi)) acc |= w[(5*i+j)*DW +: DW];
      return acc;
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Window scoreboard: every o_valid pulse is compared with the model.
   always begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
         checks++;
         if (win_idx >= W*H) begin
            failures++;
            $display("FAIL extra_window idx=%0d got=%h exp=none", win_idx, bus.o_window);
         end else begin
            logic [WIN_W-1:0] exp_w;
            exp_w = model_window(kind, win_idx / W, win_idx % W);
            if (bus.o_window !== exp_w) begin
               failures++;
               $display("FAIL window[%0d] got=%h exp=%h", win_idx, bus.o_window, exp_w);
            end
            cap[win_idx] = bus.o_window;
         end
         win_idx++;
      end
   end

   task automatic pulse_start(input int k);
      @(negedge clk);
      kind    = k;
      win_idx = 0;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Feed pixels until stop_at have been accepted; optionally check pad gaps.
   task automatic run_frame(input bit rnd, input int stop_at, input bit chk_gaps);
      int idx, cyc, low_run;
      bit drv_v, drv_r;
      idx = 0; cyc = 0; low_run = 0; drv_v = 0; drv_r = 0;
      while (idx < stop_at && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (drv_v && drv_r) idx++;
         if (chk_gaps) begin
            if (bus.ready_o !== 1'b1) low_run++;
            else if (low_run > 0) begin
               chk("pad_gap_len", low_run, 2);
               chk("pad_gap_pos", idx % W, 0);
               low_run = 0;
            end
         end
         if (idx < stop_at) drv_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         else               drv_v = 1'b0;
         bus.i_valid = drv_v;
         bus.i_data  = pix_val(kind, idx);
         drv_r       = bus.ready_o;
      end
      bus.i_valid = 1'b0;
      chk("frame_pixels_accepted", idx, stop_at);
   endtask

   // Flush progress, done flag timing and window count at end of frame.
   task automatic check_flush();
      int n1, n2, cyc;
      n1 = 0; n2 = 0; cyc = 0;
      while (i_counter !== 3'd3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (i_counter === 3'd1) n1++;
         else if (i_counter === 3'd2) n2++;
      end
      chk("flush_reached_3", i_counter, 3);
      chk("flush_row1_cycles", n1, W + 2);
      chk("flush_row2_cycles", n2, W + 2);
      chk("done_o_pulse_high", (i_counter == 3'd3 && !done_reg), 1);
      @(negedge clk);
      chk("done_reg_rise", done_reg, 1);
      chk("done_o_pulse_low", (i_counter == 3'd3 && !done_reg), 0);
      repeat (3) @(negedge clk);
      chk("done_reg_hold", done_reg, 1);
      chk("i_counter_hold", i_counter, 3);
      chk("window_count", win_idx, W*H);
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready_o", bus.ready_o, 0);
      chk("rst_o_valid", bus.o_valid, 0);
      chk("rst_o_window_zero", (bus.o_window == '0), 1);
      chk("rst_i_counter", i_counter, 0);
      chk("rst_done_reg", done_reg, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready_o", bus.ready_o, 0);

      // Frame 1: ramp image, continuous valid, pad gaps checked.
      pulse_start(0);
      chk("start_ready_o", bus.ready_o, 1);
      run_frame(1'b0, W*H, 1'b1);
      check_flush();
      chk("first_tap22", tap(cap[0], 2, 2), 1);
      chk("first_tap23", tap(cap[0], 2, 3), 2);
      chk("first_tap32", tap(cap[0], 3, 2), 9);
      chk("first_pad_band", band_or(cap[0], 0, 1), 0);
      chk("last_tap22", tap(cap[W*H-1], 2, 2), 48);
      chk("last_tap11", tap(cap[W*H-1], 1, 1), 39);
      chk("last_tap00", tap(cap[W*H-1], 0, 0), 30);
      chk("last_pad_band", band_or(cap[W*H-1], 3, 4), 0);

      // Frame 2: start from DONE, all-0xFF image.
      pulse_start(1);
      chk("redo_i_counter", i_counter, 0);
      chk("redo_done_reg", done_reg, 0);
      chk("redo_ready_o", bus.ready_o, 1);
      run_frame(1'b0, W*H, 1'b0);
      check_flush();
      chk("ff_first_tap22", tap(cap[0], 2, 2), 255);
      chk("ff_first_tap00", tap(cap[0], 0, 0), 0);
      chk("ff_mid_tap44", tap(cap[2*W+3], 4, 4), 255);

      // Frame 3: ramp image with random input bubbles.
      pulse_start(0);
      run_frame(1'b1, W*H, 1'b0);
      check_flush();

      // Frame 4: aborted by reset after 20 pixels.
      pulse_start(0);
      run_frame(1'b0, 20, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready_o", bus.ready_o, 0);
      chk("abort_o_valid", bus.o_valid, 0);
      chk("abort_o_window_zero", (bus.o_window == '0), 1);
      chk("abort_i_counter", i_counter, 0);
      chk("abort_done_reg", done_reg, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle_ready_o", bus.ready_o, 0);

      // Frame 5: fresh 0xFF frame after reset; stale ramp data must not leak.
      pulse_start(1);
      run_frame(1'b0, W*H, 1'b0);
      check_flush();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
